// File: rtl/gpio_lock_pkg.sv
//==============================================================================
// Module      : gpio_lock_pkg
// Description : Shared types, register map and STATUS layout for the GPIO
//               lock-register write-protection controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gpio_lock_pkg;

    typedef enum logic [1:0] {
        ST_PROT   = 2'd0,
        ST_K1     = 2'd1,
        ST_OPEN   = 2'd2,
        ST_FROZEN = 2'd3
    } lock_state_e;

    localparam logic [3:0] OFS_LOCK   = 4'h0;
    localparam logic [3:0] OFS_KEY    = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;
    localparam logic [3:0] OFS_FREEZE = 4'hC;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_FAIL_LSB  = 4;
    localparam int STAT_TMR_LSB   = 8;

    function automatic logic [31:0] status_word(input lock_state_e st,
                                                input logic [2:0]  fails,
                                                input logic [7:0]  tmr);
        logic [31:0] w;
        w = '0;
        w[STAT_STATE_LSB +: 2] = st;
        w[STAT_FAIL_LSB  +: 3] = fails;
        w[STAT_TMR_LSB   +: 8] = tmr;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_lock_timer.sv
//==============================================================================
// Module      : gpio_lock_timer
// Description : Loadable down-counter with zero flag; stops at zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gpio_lock_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count_en && !zero) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_gpio_lock_ctrl.sv
//==============================================================================
// Module      : apb_gpio_lock_ctrl
// Description : APB write-protection front end for the GPIO pin-lock register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_gpio_lock_ctrl
    import gpio_lock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned MAX_FAILS   = 3,
    parameter logic [31:0] KEY1        = 32'h5A5A_0001,
    parameter logic [31:0] KEY2        = 32'hA5A5_0002
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] gpio_lock,
    output logic        lock_frozen,
    output logic        tamper_irq
);

    localparam logic [7:0] TMR_INIT = 8'(TIMEOUT_CYC);
    localparam logic [2:0] MAX_F    = 3'(MAX_FAILS);

    lock_state_e state, state_nxt, eff_state;
    logic [2:0]  fail_cnt, fail_nxt, fail_inc;
    logic [31:0] lock_nxt;
    logic        irq_nxt;
    logic        bad_key;
    logic        tmr_load, tmr_zero, tmr_cnt_en;
    logic [7:0]  tmr;

    logic access, wr_acc, rd_acc, unmapped;
    logic sel_lock, sel_key, sel_freeze;

    assign access     = PSEL & PENABLE;
    assign wr_acc     = access & PWRITE;
    assign rd_acc     = access & ~PWRITE;
    assign unmapped   = (PADDR[1:0] != 2'b00);
    assign sel_lock   = (PADDR == OFS_LOCK);
    assign sel_key    = (PADDR == OFS_KEY);
    assign sel_freeze = (PADDR == OFS_FREEZE);

    assign PREADY      = 1'b1;
    assign lock_frozen = (state == ST_FROZEN);

    // An expired unlock window behaves as PROT even before the register catches up.
    assign eff_state = ((state == ST_K1 || state == ST_OPEN) && tmr_zero) ? ST_PROT : state;

    assign fail_inc   = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
    assign tmr_cnt_en = (state == ST_K1) || (state == ST_OPEN);

    gpio_lock_timer #(
        .WIDTH    (8)
    ) u_timer (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .load     (tmr_load),
        .load_val (TMR_INIT),
        .count_en (tmr_cnt_en),
        .count    (tmr),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = eff_state;
        fail_nxt  = fail_cnt;
        lock_nxt  = gpio_lock;
        irq_nxt   = 1'b0;
        tmr_load  = 1'b0;
        bad_key   = 1'b0;
        PSLVERR   = 1'b0;
        if (wr_acc) begin
            if (unmapped) begin
                PSLVERR = 1'b1;
            end else begin
                case (eff_state)
                    ST_PROT: begin
                        if (sel_key) begin
                            if (PWDATA == KEY1) begin
                                state_nxt = ST_K1;
                                tmr_load  = 1'b1;
                            end else begin
                                bad_key = 1'b1;
                            end
                        end else begin
                            PSLVERR = 1'b1;
                        end
                    end
                    ST_K1: begin
                        if (sel_key) begin
                            if (PWDATA == KEY2) begin
                                state_nxt = ST_OPEN;
                                tmr_load  = 1'b1;
                            end else begin
                                bad_key = 1'b1;
                            end
                        end else begin
                            PSLVERR   = 1'b1;
                            state_nxt = ST_PROT;
                        end
                    end
                    ST_OPEN: begin
                        if (sel_lock) begin
                            lock_nxt  = gpio_lock | PWDATA;
                            fail_nxt  = 3'd0;
                            state_nxt = ST_PROT;
                        end else if (sel_freeze) begin
                            if (PWDATA[0]) begin
                                state_nxt = ST_FROZEN;
                            end
                        end else if (sel_key) begin
                            bad_key = 1'b1;
                        end else begin
                            PSLVERR = 1'b1;
                        end
                    end
                    default: begin
                        PSLVERR = 1'b1;
                    end
                endcase
            end
            if (bad_key) begin
                PSLVERR  = 1'b1;
                fail_nxt = fail_inc;
                if (fail_inc == MAX_F) begin
                    state_nxt = ST_FROZEN;
                    irq_nxt   = 1'b1;
                end else begin
                    state_nxt = ST_PROT;
                end
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_acc) begin
            case (PADDR)
                OFS_LOCK:   PRDATA = gpio_lock;
                OFS_STATUS: PRDATA = status_word(eff_state, fail_cnt, tmr);
                default:    PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_PROT;
            fail_cnt   <= 3'd0;
            gpio_lock  <= '0;
            tamper_irq <= 1'b0;
        end else begin
            state      <= state_nxt;
            fail_cnt   <= fail_nxt;
            gpio_lock  <= lock_nxt;
            tamper_irq <= irq_nxt;
        end
    end

endmodule

`default_nettype wire

// File: doc/apb_gpio_lock_ctrl.md
Name: apb_gpio_lock_ctrl

Overview:
Write-protection controller for the GPIO pin-lock register, sitting between the APB GPIO slave decode and the r_gpio_lock storage.
- Lock register is protected out of reset; opening it requires a two-word key sequence within a timeout.
- Lock bits are sticky-set only.
- Repeated bad keys freeze the block until reset.
- Closes the "protection cleared on reset" hole: reset always yields the protected state.

Parameters:
- TIMEOUT_CYC, 16, cycles a partially/fully unlocked state survives before auto-relock (1..255).
- MAX_FAILS, 3, consecutive bad key writes that force FROZEN (1..7).
- KEY1, 32'h5A5A_0001, first unlock key.
- KEY2, 32'hA5A5_0002, second unlock key.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select for this block.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write.
- PADDR  in  4  byte offset; 0x0 LOCK, 0x4 KEY, 0x8 STATUS, 0xC FREEZE.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error response, valid in access phase.
- gpio_lock  out  32  per-pin lock bits to the GPIO core.
- lock_frozen  out  1  high in FROZEN.
- tamper_irq  out  1  one-cycle pulse on fail-induced FROZEN entry.

Behaviour:
- Access = PSEL & PENABLE. Decisions are combinational in the access cycle; all state updates at the next HCLK rise.
- Reset values: state=PROT, gpio_lock=0, fail_cnt=0, tmr=0, lock_frozen=0, tamper_irq=0, PRDATA=0, PSLVERR=0. Reset mid-sequence aborts to PROT.
- Effective state: if state is K1 or OPEN and tmr==0, the state is treated as PROT for that cycle's access. Expiry wins over a coincident access.
- PROT:
  - Write KEY == KEY1: go to K1, tmr <= TIMEOUT_CYC.
  - Write KEY with any other value: fail.
  - Write LOCK or FREEZE: PSLVERR=1, no change.
- K1:
  - Write KEY == KEY2: go to OPEN, tmr <= TIMEOUT_CYC.
  - Write KEY with any other value: fail.
  - Any other write: PSLVERR=1, go to PROT.
- OPEN:
  - Write LOCK: gpio_lock <= gpio_lock | PWDATA, fail_cnt <= 0, go to PROT.
  - Write FREEZE with PWDATA[0]=1: go to FROZEN, no irq.
  - Write FREEZE with PWDATA[0]=0: no-op, stay.
  - Write KEY: fail.
- FROZEN: all writes give PSLVERR=1 with no effect. Exit only via HRESETn.
- Fail handling:
  - PSLVERR=1.
  - fail_cnt+1; if the result equals MAX_FAILS: go to FROZEN, pulse tamper_irq.
  - Otherwise go to PROT.
  - fail_cnt saturates and clears only on a successful LOCK commit or reset.
- Timer: in K1/OPEN, tmr decrements by 1 each cycle while nonzero. It does not count in PROT/FROZEN.
- gpio_lock bits never clear except by reset. Writing 0 bits has no effect.
- Reads (never error, no side effects):
  - LOCK returns gpio_lock.
  - STATUS returns {16'h0, tmr[7:0], 1'b0, fail_cnt[2:0], 2'b0, state[1:0]}; state encoding PROT=0, K1=1, OPEN=2, FROZEN=3.
  - KEY and FREEZE read 0.
  - PRDATA is registered-free combinational from current state and is 0 when there is no access.
- Unmapped PADDR (any bits [1:0] != 0): writes PSLVERR=1 with no state change (not counted as fail); reads return 0.
- lock_frozen is a direct decode of state==FROZEN.

Decomposition:
- Package gpio_lock_pkg:
  - state enum lock_state_e.
  - register offset localparams.
  - STATUS field positions.
- One sub-module, gpio_lock_timer: loadable down-counter with a zero flag.
- FSM, registers and APB decode stay in the top.

Test Plan:
1. Unlock and commit. After reset, write KEY=5A5A0001, then KEY=A5A50002, then LOCK=0000_00F0 -> no PSLVERR; gpio_lock=0x000000F0; STATUS state=0. Then repeat the sequence with LOCK=0x0F -> gpio_lock=0x000000FF (sticky OR).
2. Locked write rejected. Write LOCK=0xFFFFFFFF from PROT -> PSLVERR=1; gpio_lock unchanged; fail_cnt=0.
3. Timeout. After KEY1, KEY2, idle 16 cycles, then write LOCK=1 -> PSLVERR=1, gpio_lock unchanged. Also: a LOCK write on the exact expiry cycle is rejected.
4. Tamper. Write KEY=0, KEY=0, KEY=0 -> fail_cnt steps 1,2; the third write causes a tamper_irq pulse one cycle, lock_frozen=1, and a later valid sequence errors. Assert HRESETn -> PROT, fail_cnt=0.
5. Software freeze. KEY1, KEY2, then FREEZE=1 -> lock_frozen=1, tamper_irq stays 0, LOCK writes error.
6. Reset mid-sequence. KEY1, KEY2, pulse HRESETn low, then write LOCK=1 -> PSLVERR=1; gpio_lock=0; STATUS=0.
